// File: rtl/alu_op_sequencer.sv
// -----------------------------------------------------------------------------
// alu_op_sequencer
//
// Initiator side of an 8-bit combinational ALU. Accepts 16-bit operation
// requests over a valid/ready handshake, splits each into 8-bit micro-ops
// (low byte, high byte, then an optional +1 fix-up on the high byte when a
// kADD low byte carried out), and returns a 16-bit result plus carry over a
// second valid/ready handshake.
//
// Ports:
//   CLK, Reset_n              clock (rising edge), async active-low reset
//   ReqValid/ReqReady         request handshake
//   ReqOp, ReqA, ReqB         request opcode and 16-bit operands
//   ALUOp, InputA, InputB     registered micro-op driven to the ALU
//   Out, CarryOut             combinational ALU result and carry
//   RespValid/RespReady       response handshake
//   RespData, RespCarry       16-bit result and carry out
//   StatCount, StatFixups     completed transactions / fix-ups issued
//
// Optional feature: define ALU_OP_SEQUENCER_STATS_EN to build the two 16-bit
// wrapping statistics counters. Without it both stat ports are tied to 0.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | ReqReady=1, waiting for a request; ALU inputs at reset values
// LO    | low byte micro-op on the ALU
// HI    | high byte micro-op on the ALU
// FIX   | kADD only: high byte + 1 to absorb the low byte carry
// RESP  | RespValid=1, result held until RespReady
// -----------------------------------------------------------------------------
module alu_op_sequencer #(
    parameter int OP_W = 4
) (
    input  logic            CLK,
    input  logic            Reset_n,
    input  logic            ReqValid,
    output logic            ReqReady,
    input  logic [OP_W-1:0] ReqOp,
    input  logic [15:0]     ReqA,
    input  logic [15:0]     ReqB,
    output logic [OP_W-1:0] ALUOp,
    output logic [7:0]      InputA,
    output logic [7:0]      InputB,
    input  logic [7:0]      Out,
    input  logic            CarryOut,
    output logic            RespValid,
    input  logic            RespReady,
    output logic [15:0]     RespData,
    output logic            RespCarry,
    output logic [15:0]     StatCount,
    output logic [15:0]     StatFixups
);

    // Opcode encodings shared with the ALU definitions.
    localparam logic [OP_W-1:0] K_PASS_INPUTA = OP_W'(0);
    localparam logic [OP_W-1:0] K_PASS_INPUTB = OP_W'(1);
    localparam logic [OP_W-1:0] K_ADD         = OP_W'(2);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LO   = 3'd1,
        S_HI   = 3'd2,
        S_FIX  = 3'd3,
        S_RESP = 3'd4
    } state_t;

    state_t          state_q,      state_d;
    logic [OP_W-1:0] op_q,         op_d;
    logic [15:0]     a_q,          a_d;
    logic [15:0]     b_q,          b_d;
    logic            c_lo_q,       c_lo_d;
    logic            c_hi_q,       c_hi_d;
    logic [OP_W-1:0] alu_op_q,     alu_op_d;
    logic [7:0]      in_a_q,       in_a_d;
    logic [7:0]      in_b_q,       in_b_d;
    logic [15:0]     resp_data_q,  resp_data_d;
    logic            resp_carry_q, resp_carry_d;
    logic            req_ready_q,  req_ready_d;
    logic            resp_valid_q, resp_valid_d;

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        a_d          = a_q;
        b_d          = b_q;
        c_lo_d       = c_lo_q;
        c_hi_d       = c_hi_q;
        resp_data_d  = resp_data_q;
        resp_carry_d = resp_carry_q;

        case (state_q)
            S_IDLE: begin
                if (ReqValid && req_ready_q) begin
                    op_d    = ReqOp;
                    a_d     = ReqA;
                    b_d     = ReqB;
                    state_d = S_LO;
                end
            end
            S_LO: begin
                resp_data_d[7:0] = Out;
                c_lo_d           = CarryOut;
                state_d          = S_HI;
            end
            S_HI: begin
                resp_data_d[15:8] = Out;
                c_hi_d            = CarryOut;
                // Non-add ops are bytewise with no carry chaining.
                resp_carry_d      = (op_q == K_ADD) ? CarryOut : 1'b0;
                if ((op_q == K_ADD) && c_lo_q) begin
                    state_d = S_FIX;
                end else begin
                    state_d = S_RESP;
                end
            end
            S_FIX: begin
                resp_data_d[15:8] = Out;
                resp_carry_d      = c_hi_q | CarryOut;
                state_d           = S_RESP;
            end
            S_RESP: begin
                if (RespReady) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // ALU inputs are registered, so they are set up for the state being
        // entered. The FIX operand is the freshly captured high byte.
        case (state_d)
            S_LO: begin
                alu_op_d = op_d;
                in_a_d   = a_d[7:0];
                in_b_d   = b_d[7:0];
            end
            S_HI: begin
                alu_op_d = op_q;
                in_a_d   = a_q[15:8];
                in_b_d   = b_q[15:8];
            end
            S_FIX: begin
                alu_op_d = K_ADD;
                in_a_d   = resp_data_d[15:8];
                in_b_d   = 8'h01;
            end
            default: begin
                alu_op_d = K_PASS_INPUTA;
                in_a_d   = 8'h00;
                in_b_d   = 8'h00;
            end
        endcase

        req_ready_d  = (state_d == S_IDLE);
        resp_valid_d = (state_d == S_RESP);
    end

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q      <= S_IDLE;
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            c_lo_q       <= 1'b0;
            c_hi_q       <= 1'b0;
            alu_op_q     <= K_PASS_INPUTA;
            in_a_q       <= '0;
            in_b_q       <= '0;
            resp_data_q  <= '0;
            resp_carry_q <= 1'b0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            a_q          <= a_d;
            b_q          <= b_d;
            c_lo_q       <= c_lo_d;
            c_hi_q       <= c_hi_d;
            alu_op_q     <= alu_op_d;
            in_a_q       <= in_a_d;
            in_b_q       <= in_b_d;
            resp_data_q  <= resp_data_d;
            resp_carry_q <= resp_carry_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
        end
    end

    assign ReqReady  = req_ready_q;
    assign RespValid = resp_valid_q;
    assign RespData  = resp_data_q;
    assign RespCarry = resp_carry_q;
    assign ALUOp     = alu_op_q;
    assign InputA    = in_a_q;
    assign InputB    = in_b_q;

`ifdef ALU_OP_SEQUENCER_STATS_EN
    logic [15:0] stat_count_q,  stat_count_d;
    logic [15:0] stat_fixups_q, stat_fixups_d;

    always_comb begin
        stat_count_d  = stat_count_q;
        stat_fixups_d = stat_fixups_q;
        if ((state_q == S_RESP) && (state_d == S_IDLE)) begin
            stat_count_d = stat_count_q + 16'd1;
        end
        if ((state_q == S_FIX) && (state_d == S_RESP)) begin
            stat_fixups_d = stat_fixups_q + 16'd1;
        end
    end

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            stat_count_q  <= '0;
            stat_fixups_q <= '0;
        end else begin
            stat_count_q  <= stat_count_d;
            stat_fixups_q <= stat_fixups_d;
        end
    end

    assign StatCount  = stat_count_q;
    assign StatFixups = stat_fixups_q;
`else
    assign StatCount  = 16'h0000;
    assign StatFixups = 16'h0000;
`endif

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Initiator side of the 8-bit ALU interface (ALUOp / InputA / InputB in; Out / CarryOut back).
- Accepts 16-bit operation requests over a valid/ready handshake and splits each into sequenced 8-bit ALU micro-ops: low byte, high byte, then an optional carry fix-up.
- Returns a 16-bit result plus carry over a second valid/ready handshake.
- Sits between the execute-stage decode and the combinational ALU, so multi-byte arithmetic works without changing the ALU.

Parameters:
- OP_W, 4, width of the ALU opcode; matches the definitions package opcode type.

Ports:
- CLK  in  1  clock, rising edge.
- Reset_n  in  1  asynchronous active-low reset.
- ReqValid  in  1  request valid.
- ReqReady  out  1  sequencer can accept a request.
- ReqOp  in  OP_W  opcode (kADD, kPASS_INPUTA, kPASS_INPUTB, others).
- ReqA  in  16  operand A.
- ReqB  in  16  operand B.
- ALUOp  out  OP_W  opcode driven to the ALU.
- InputA  out  8  ALU operand A.
- InputB  out  8  ALU operand B.
- Out  in  8  ALU result (combinational from ALUOp/InputA/InputB).
- CarryOut  in  1  ALU carry.
- RespValid  out  1  result valid.
- RespReady  in  1  consumer accepts result.
- RespData  out  16  result.
- RespCarry  out  1  16-bit carry out.
- StatCount  out  16  completed transactions (optional feature).
- StatFixups  out  16  fix-up micro-ops issued (optional feature).

Behaviour:
- Reset (async, Reset_n=0):
  - state=IDLE.
  - ReqReady=1, RespValid=0, RespData=0, RespCarry=0.
  - ALUOp=kPASS_INPUTA, InputA=0, InputB=0.
  - Captured operands and stat counters cleared.
  - A reset mid-transaction abandons it; no response is produced.
- States: IDLE, LO, HI, FIX, RESP.
- ReqReady=1 only in IDLE. RespValid=1 only in RESP.
- IDLE:
  - On ReqValid&&ReqReady at an edge, capture ReqOp/ReqA/ReqB, then go to LO.
  - ALU outputs are held at their reset values.
- LO:
  - Drive ALUOp=op, InputA=A[7:0], InputB=B[7:0].
  - At the edge, capture Out into RespData[7:0] and CarryOut into c_lo, then go to HI.
- HI:
  - Drive ALUOp=op, InputA=A[15:8], InputB=B[15:8].
  - At the edge, capture Out into RespData[15:8] and CarryOut into c_hi.
  - If op==kADD and c_lo==1, go to FIX; otherwise go to RESP.
- FIX:
  - Drive ALUOp=kADD, InputA=RespData[15:8], InputB=8'h01.
  - At the edge, capture Out into RespData[15:8] and CarryOut into c_fix, then go to RESP.
- RespCarry:
  - For kADD: c_hi | c_fix.
  - For all other ops: 0. They are processed bytewise with no carry chaining.
- RESP:
  - RespData and RespCarry are held stable while RespValid=1 and RespReady=0.
  - On RespReady=1 at an edge, go to IDLE.
  - There is no same-cycle RESP→accept bypass; ReqReady rises the cycle after completion.
- Latency, accept edge to RespValid high:
  - 3 edges without fix-up.
  - 4 edges with fix-up.
- Throughput: at most one transaction per 4 (or 5) cycles.
- Request inputs are ignored outside IDLE. ReqValid held high while busy is not an error.
- The ALU is combinational: Out/CarryOut are sampled at the end of the same cycle the operands are driven.

Optional Feature:
- Macro ALU_OP_SEQUENCER_STATS_EN.
- When defined:
  - StatCount increments on each RESP→IDLE transition.
  - StatFixups increments on each FIX→RESP transition.
  - Both counters are 16-bit, wrap 0xFFFF→0x0000, and clear on reset.
- When undefined: both ports are tied to 0 and no counter flops exist.

Test Plan:
- kADD 0x1234+0x0101, RespReady=1 → RespValid 3 cycles after accept, RespData=0x1335, RespCarry=0, FIX never entered.
- kADD 0x00FF+0x0001 → FIX entered with InputA=0x00 and InputB=0x01; RespData=0x0100, RespCarry=0, latency 4.
- kADD 0xFFFF+0x0001 → RespData=0x0000, RespCarry=1 (via c_fix).
- kPASS_INPUTB with B=0xABCD and RespReady held low 5 cycles → RespData=0xABCD stable throughout, RespCarry=0, ReqReady=0 until the cycle after RespReady is seen.
- Reset_n pulsed low during HI of kADD 0x80FF+0x80FF → outputs return to reset values immediately with no response. The next request 0x0002+0x0003 returns 0x0005.
- With ALU_OP_SEQUENCER_STATS_EN, the three kADD transactions above → StatCount=3, StatFixups=2.
